// File: rtl/rotate_share_ctrl.sv
// Two-requester round-robin front end for a single rotate-right datapath.
// Left rotates are folded into right rotates. Results go out through a one-entry registered response slot.
module rotate_share_ctrl #(
  parameter int W = 8,
  localparam int AW = $clog2(W)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req0_valid_i,
  output logic          req0_ready_o,
  input  logic [W-1:0]  req0_data_i,
  input  logic [AW-1:0] req0_amt_i,
  input  logic          req0_dir_i,
  input  logic          req1_valid_i,
  output logic          req1_ready_o,
  input  logic [W-1:0]  req1_data_i,
  input  logic [AW-1:0] req1_amt_i,
  input  logic          req1_dir_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [W-1:0]  rsp_data_o,
  output logic          rsp_id_o
);

  typedef enum logic {EMPTY, FULL} state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  rsp_data_q, rsp_data_d;
  logic          rsp_id_q, rsp_id_d;
  logic          last_grant_q, last_grant_d;

  logic          can_load;
  logic          grant0, grant1;
  logic          accept;
  logic          sel;
  logic [W-1:0]  sel_data;
  logic [AW-1:0] sel_amt;
  logic          sel_dir;
  logic [AW-1:0] right_amt;
  logic [W-1:0]  rotated;

  function automatic logic [W-1:0] rotr(input logic [W-1:0] d, input logic [AW-1:0] k);
    return W'({d, d} >> k);
  endfunction

  // On a tie the requester that did not win last time gets the slot.
  assign can_load = (state_q == EMPTY) || rsp_ready_i;
  assign grant0   = req0_valid_i && (!req1_valid_i || last_grant_q);
  assign grant1   = req1_valid_i && (!req0_valid_i || !last_grant_q);

  assign req0_ready_o = reset_n && grant0 && can_load;
  assign req1_ready_o = reset_n && grant1 && can_load;
  assign accept       = req0_ready_o || req1_ready_o;

  assign sel      = grant1;
  assign sel_data = sel ? req1_data_i : req0_data_i;
  assign sel_amt  = sel ? req1_amt_i  : req0_amt_i;
  assign sel_dir  = sel ? req1_dir_i  : req0_dir_i;

  // Left by k equals right by (W-k) mod W; the AW-bit negate wraps 0 back to 0.
  assign right_amt = sel_dir ? (~sel_amt + 1'b1) : sel_amt;
  assign rotated   = rotr(sel_data, right_amt);

  always_comb begin
    state_d      = state_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    last_grant_d = last_grant_q;
    if (accept) begin
      state_d      = FULL;
      rsp_data_d   = rotated;
      rsp_id_d     = sel;
      last_grant_d = sel;
    end else if (state_q == FULL && rsp_ready_i) begin
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= EMPTY;
      rsp_data_q   <= '0;
      rsp_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign rsp_valid_o = (state_q == FULL);
  assign rsp_data_o  = rsp_data_q;
  assign rsp_id_o    = rsp_id_q;

endmodule

// File: tb/tb_rotate_share_ctrl.sv
// Self-checking bench for rotate_share_ctrl: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a behavioural model (bit-by-bit rotate, round-robin rules).
module tb_rotate_share_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic [2:0] a0 = '0, a1 = '0;
  logic       dir0 = 1'b0, dir1 = 1'b0;
  logic       rr = 1'b0;
  logic       rdy0, rdy1;
  logic       rspValid;
  logic [7:0] rspData;
  logic       rspId;

  int checkCount = 0;
  int errorCount = 0;

  // Behavioural model state
  logic       mValid;
  logic [7:0] mData;
  logic       mId;
  int         mLast;
  logic       acc0, acc1;

  typedef struct packed {
    logic v0; logic [7:0] d0; logic [2:0] a0; logic dir0;
    logic v1; logic [7:0] d1; logic [2:0] a1; logic dir1;
    logic rr;
    logic eRdy0; logic eRdy1; logic eValid; logic [7:0] eData; logic eId;
  } vec_t;

  vec_t vecs [9];

  rotate_share_ctrl #(.W(8)) dut (
    .clk(clk), .reset_n(reset_n),
    .req0_valid_i(v0), .req0_ready_o(rdy0), .req0_data_i(d0), .req0_amt_i(a0), .req0_dir_i(dir0),
    .req1_valid_i(v1), .req1_ready_o(rdy1), .req1_data_i(d1), .req1_amt_i(a1), .req1_dir_i(dir1),
    .rsp_valid_o(rspValid), .rsp_ready_i(rr), .rsp_data_o(rspData), .rsp_id_o(rspId)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] refRot(input logic [7:0] d, input logic [2:0] k, input logic left);
    logic [7:0] r;
    r = d;
    for (int i = 0; i < int'(k); i++)
      r = left ? {r[6:0], r[7]} : {r[0], r[7:1]};
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic iv0, input logic [7:0] id0, input logic [2:0] ia0, input logic idir0,
                               input logic iv1, input logic [7:0] id1, input logic [2:0] ia1, input logic idir1,
                               input logic irr);
    v0 = iv0; d0 = id0; a0 = ia0; dir0 = idir0;
    v1 = iv1; d1 = id1; a1 = ia1; dir1 = idir1;
    rr = irr;
  endtask

  task automatic modelReset();
    mValid = 1'b0; mData = '0; mId = 1'b0; mLast = 1;
  endtask

  // One clock: readies checked mid-cycle against the model, outputs checked just after the edge.
  task automatic cycle();
    logic canLoad;
    int   win;
    logic e0, e1;
    @(negedge clk);
    canLoad = !mValid || rr;
    win = -1;
    if (v0 && v1)  win = 1 - mLast;
    else if (v0)   win = 0;
    else if (v1)   win = 1;
    e0 = canLoad && (win == 0);
    e1 = canLoad && (win == 1);
    checkOutput("req0_ready", 32'(rdy0), 32'(e0));
    checkOutput("req1_ready", 32'(rdy1), 32'(e1));
    @(posedge clk);
    #1;
    if (e0) begin
      mValid = 1'b1; mData = refRot(d0, a0, dir0); mId = 1'b0; mLast = 0;
    end else if (e1) begin
      mValid = 1'b1; mData = refRot(d1, a1, dir1); mId = 1'b1; mLast = 1;
    end else if (mValid && rr) begin
      mValid = 1'b0;
    end
    acc0 = e0;
    acc1 = e1;
    checkOutput("rsp_valid", 32'(rspValid), 32'(mValid));
    checkOutput("rsp_data", 32'(rspData), 32'(mData));
    checkOutput("rsp_id", 32'(rspId), 32'(mId));
  endtask

  // Drops reset asynchronously away from any edge, checks the cleared outputs, releases mid-cycle.
  task automatic doReset();
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("reset_rsp_valid", 32'(rspValid), 32'd0);
    checkOutput("reset_rsp_data", 32'(rspData), 32'd0);
    checkOutput("reset_rsp_id", 32'(rspId), 32'd0);
    checkOutput("reset_req0_ready", 32'(rdy0), 32'd0);
    checkOutput("reset_req1_ready", 32'(rdy1), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset_n = 1'b1;
    modelReset();
  endtask

  initial begin
    $display("[TB] start");
    modelReset();
    acc0 = 1'b0; acc1 = 1'b0;

    vecs[0] = '{1'b1, 8'hB1, 3'd3, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h36, 1'b0};
    vecs[1] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'hB1, 3'd3, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h8D, 1'b1};
    vecs[2] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'h5A, 3'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b1};
    vecs[3] = '{1'b1, 8'h5A, 3'd0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0};
    vecs[4] = '{1'b1, 8'h01, 3'd1, 1'b0, 1'b1, 8'h01, 3'd1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h02, 1'b1};
    vecs[5] = '{1'b1, 8'h01, 3'd1, 1'b0, 1'b1, 8'h01, 3'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0};
    vecs[6] = '{1'b1, 8'h01, 3'd1, 1'b0, 1'b1, 8'h01, 3'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80, 1'b0};
    vecs[7] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0};
    vecs[8] = '{1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h80, 1'b0};

    doReset();

    // Directed vector table, checked against hand-derived constants and the model.
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].v0, vecs[i].d0, vecs[i].a0, vecs[i].dir0,
                    vecs[i].v1, vecs[i].d1, vecs[i].a1, vecs[i].dir1, vecs[i].rr);
      cycle();
      checkOutput($sformatf("vec%0d_rdy0", i), 32'(acc0), 32'(vecs[i].eRdy0));
      checkOutput($sformatf("vec%0d_rdy1", i), 32'(acc1), 32'(vecs[i].eRdy1));
      checkOutput($sformatf("vec%0d_valid", i), 32'(rspValid), 32'(vecs[i].eValid));
      checkOutput($sformatf("vec%0d_data", i), 32'(rspData), 32'(vecs[i].eData));
      checkOutput($sformatf("vec%0d_id", i), 32'(rspId), 32'(vecs[i].eId));
    end

    // Full amount sweep in both directions.
    for (int dir = 0; dir < 2; dir++)
      for (int k = 0; k < 8; k++) begin
        applyStimulus(1'b1, 8'hB1, 3'(k), 1'(dir), 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
        cycle();
      end

    // Continuous contention after reset: grants 0,1,0,1,...
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'(8'h10 + i), 3'(i), 1'b0, 1'b1, 8'(8'h20 + i), 3'(i), 1'b1, 1'b1);
      cycle();
      checkOutput("alt_id", 32'(rspId), 32'(i % 2));
      checkOutput("alt_valid", 32'(rspValid), 32'd1);
    end

    // Backpressure for 4 cycles with a result pending, then release.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 8'hC3, 3'd2, 1'b1, 1'b1, 8'h3C, 3'd5, 1'b0, 1'b0);
      cycle();
      checkOutput("stall_no_accept", 32'({acc0, acc1}), 32'd0);
      checkOutput("stall_id_held", 32'(rspId), 32'd1);
    end
    applyStimulus(1'b1, 8'hC3, 3'd2, 1'b1, 1'b1, 8'h3C, 3'd5, 1'b0, 1'b1);
    cycle();
    checkOutput("stall_release_accept0", 32'(acc0), 32'd1);
    checkOutput("stall_release_data", 32'(rspData), 32'h0F);

    // Reset while a response is pending, then a tie must go to requester 0.
    checkOutput("pre_reset_valid", 32'(rspValid), 32'd1);
    doReset();
    applyStimulus(1'b1, 8'h81, 3'd1, 1'b0, 1'b1, 8'h81, 3'd1, 1'b1, 1'b1);
    cycle();
    checkOutput("post_reset_winner", 32'(rspId), 32'd0);

    // Only requester 1 for three operations in a row.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'(8'hA0 + i), 3'(i + 1), 1'b0, 1'b1);
      cycle();
      checkOutput("solo1_accept", 32'(acc1), 32'd1);
      checkOutput("solo1_id", 32'(rspId), 32'd1);
    end

    // Randomized traffic; requesters hold operands until accepted.
    v0 = 1'b0; v1 = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
    for (int n = 0; n < 500; n++) begin
      if (!v0 || acc0) begin
        v0 = ($urandom_range(0, 3) != 0); d0 = 8'($urandom); a0 = 3'($urandom); dir0 = 1'($urandom);
      end
      if (!v1 || acc1) begin
        v1 = ($urandom_range(0, 3) != 0); d1 = 8'($urandom); a1 = 3'($urandom); dir1 = 1'($urandom);
      end
      rr = ($urandom_range(0, 3) != 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
